// File: rtl/pwm_shadow_ctrl.sv
// Shadow-register controller for a PWM generator: buffers a configuration and commits it atomically at the end of a PWM period.
// Optional input validation is enabled by defining PWM_SHADOW_VALIDATE_EN.
module pwm_shadow_ctrl #(
    parameter logic [15:0] RST_PERIOD    = 16'd255,
    parameter logic [7:0]  RST_FUNCTIONS = 8'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [15:0] cfg_period,
    input  logic [15:0] cfg_compare1,
    input  logic [15:0] cfg_compare2,
    input  logic [7:0]  cfg_functions,
    input  logic        cfg_abort,
    input  logic        pwm_en_req,
    input  logic [15:0] count_val,
    output logic [15:0] period,
    output logic [15:0] compare1,
    output logic [15:0] compare2,
    output logic [7:0]  functions,
    output logic        pwm_en,
    output logic        update_done,
    output logic        cfg_err
);

    typedef enum logic [1:0] {IDLE, PENDING, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] sh_period_q, sh_period_d, sh_cmp1_q, sh_cmp1_d, sh_cmp2_q, sh_cmp2_d;
    logic [7:0]  sh_func_q, sh_func_d;
    logic [15:0] period_q, period_d, cmp1_q, cmp1_d, cmp2_q, cmp2_d;
    logic [7:0]  func_q, func_d;
    logic        pwm_en_q;
    logic        transfer;
    logic        cfg_bad;

    assign transfer = cfg_valid && (state_q == IDLE);

`ifdef PWM_SHADOW_VALIDATE_EN
    logic cfg_err_q;

    assign cfg_bad = (cfg_period == 16'd0) ||
                     (cfg_functions[1:0] == 2'b11) ||
                     ((cfg_functions[1:0] == 2'b10) && (cfg_compare1 >= cfg_compare2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_err_q <= 1'b0;
        else        cfg_err_q <= transfer && cfg_bad;
    end

    assign cfg_err = cfg_err_q;
`else
    assign cfg_bad = 1'b0;
    assign cfg_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sh_period_d = sh_period_q;
        sh_cmp1_d   = sh_cmp1_q;
        sh_cmp2_d   = sh_cmp2_q;
        sh_func_d   = sh_func_q;
        period_d    = period_q;
        cmp1_d      = cmp1_q;
        cmp2_d      = cmp2_q;
        func_d      = func_q;
        case (state_q)
            IDLE: begin
                if (transfer && !cfg_bad) begin
                    sh_period_d = cfg_period;
                    sh_cmp1_d   = cfg_compare1;
                    sh_cmp2_d   = cfg_compare2;
                    sh_func_d   = cfg_functions;
                    state_d     = PENDING;
                end
            end
            PENDING: begin
                // Abort has priority over a commit on the same edge.
                if (cfg_abort) begin
                    state_d = IDLE;
                end else if (!pwm_en_q || (count_val == period_q)) begin
                    period_d = sh_period_q;
                    cmp1_d   = sh_cmp1_q;
                    cmp2_d   = sh_cmp2_q;
                    func_d   = sh_func_q;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sh_period_q <= '0;
            sh_cmp1_q   <= '0;
            sh_cmp2_q   <= '0;
            sh_func_q   <= '0;
            period_q    <= RST_PERIOD;
            cmp1_q      <= '0;
            cmp2_q      <= '0;
            func_q      <= RST_FUNCTIONS;
            pwm_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_period_q <= sh_period_d;
            sh_cmp1_q   <= sh_cmp1_d;
            sh_cmp2_q   <= sh_cmp2_d;
            sh_func_q   <= sh_func_d;
            period_q    <= period_d;
            cmp1_q      <= cmp1_d;
            cmp2_q      <= cmp2_d;
            func_q      <= func_d;
            pwm_en_q    <= pwm_en_req;
        end
    end

    assign cfg_ready   = (state_q == IDLE);
    assign update_done = (state_q == DONE);
    assign period      = period_q;
    assign compare1    = cmp1_q;
    assign compare2    = cmp2_q;
    assign functions   = func_q;
    assign pwm_en      = pwm_en_q;

endmodule
